// File: rtl/logic48_pkg.sv
// -----------------------------------------------------------------------------
// logic48_pkg
// Shared definitions for the 48-bit logic scheduler:
//   DATA_W / OP_W   - datapath and opcode widths
//   op_e            - the eight bitwise opcodes (OP_AND .. OP_PASSA)
//   data_t, tag_t   - datapath word and result-tag types
//   f_logic()       - bitwise evaluation of one opcode
// -----------------------------------------------------------------------------
package logic48_pkg;

    localparam int DATA_W = 48;
    localparam int OP_W   = 3;

    typedef logic [DATA_W-1:0] data_t;

    typedef enum logic [OP_W-1:0] {
        OP_AND   = 3'd0,
        OP_OR    = 3'd1,
        OP_XOR   = 3'd2,
        OP_NAND  = 3'd3,
        OP_NOR   = 3'd4,
        OP_XNOR  = 3'd5,
        OP_ANDN  = 3'd6,
        OP_PASSA = 3'd7
    } op_e;

    // One slot of the result tag pipeline: is there an operation, and who issued it.
    typedef struct packed {
        logic valid;
        logic id;
    } tag_t;

    // Bitwise result of one opcode across the full data width.
    function automatic data_t f_logic(input logic [OP_W-1:0] op, input data_t a, input data_t b);
        data_t r;
        case (op)
            OP_AND:   r = a & b;
            OP_OR:    r = a | b;
            OP_XOR:   r = a ^ b;
            OP_NAND:  r = ~(a & b);
            OP_NOR:   r = ~(a | b);
            OP_XNOR:  r = ~(a ^ b);
            OP_ANDN:  r = a & ~b;
            OP_PASSA: r = a;
            default:  r = a;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/logic48_sched_if.sv
// -----------------------------------------------------------------------------
// logic48_sched_if
// Request/result bundle between two requesters and the logic48 scheduler.
//   REQn_VALID/READY/OP/A/B - per-requester handshake and operands (n = 0, 1)
//   RES_VALID/RES_ID/RES_DATA - in-order result stream
//   BUSY                     - operation(s) in flight
// Modports: master = requester side, slave = scheduler side.
// -----------------------------------------------------------------------------
interface logic48_sched_if;
    import logic48_pkg::*;

    logic            REQ0_VALID;
    logic            REQ0_READY;
    logic [OP_W-1:0] REQ0_OP;
    data_t           REQ0_A;
    data_t           REQ0_B;

    logic            REQ1_VALID;
    logic            REQ1_READY;
    logic [OP_W-1:0] REQ1_OP;
    data_t           REQ1_A;
    data_t           REQ1_B;

    logic            RES_VALID;
    logic            RES_ID;
    data_t           RES_DATA;
    logic            BUSY;

    modport master (
        output REQ0_VALID, REQ0_OP, REQ0_A, REQ0_B,
        output REQ1_VALID, REQ1_OP, REQ1_A, REQ1_B,
        input  REQ0_READY, REQ1_READY,
        input  RES_VALID, RES_ID, RES_DATA, BUSY
    );

    modport slave (
        input  REQ0_VALID, REQ0_OP, REQ0_A, REQ0_B,
        input  REQ1_VALID, REQ1_OP, REQ1_A, REQ1_B,
        output REQ0_READY, REQ1_READY,
        output RES_VALID, RES_ID, RES_DATA, BUSY
    );

endinterface

// File: rtl/logic48_core.sv
// -----------------------------------------------------------------------------
// logic48_core
// Pipelined 48-bit bitwise logic unit with LAT register stages. The first
// stage registers the evaluated result (like a DSP48E logic-mode slice with
// its operand/ALUMODE path folded into one registered stage); the remaining
// stages are pure delay so the result appears on P LAT-1 edges after capture.
//   CLK, RST : clock, synchronous active-high reset
//   OP, A, B : opcode and operands, captured every edge
//   P        : result of the operands captured LAT-1 edges earlier
// -----------------------------------------------------------------------------
module logic48_core
    import logic48_pkg::*;
#(
    parameter int LAT = 2
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [OP_W-1:0] OP,
    input  data_t           A,
    input  data_t           B,
    output data_t           P
);

    data_t r_stage [LAT];

    // Result pipeline: evaluate into stage 0, then shift toward P.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < LAT; i++) begin
                r_stage[i] <= {DATA_W{1'b0}};
            end
        end else begin
            r_stage[0] <= f_logic(OP, A, B);
            for (int i = 1; i < LAT; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign P = r_stage[LAT-1];

endmodule

// File: rtl/logic48_sched.sv
// -----------------------------------------------------------------------------
// logic48_sched
// Two-requester round-robin front end for the pipelined 48-bit logic unit.
//   CLK, RST : clock, synchronous active-high reset
//   bus      : logic48_sched_if.slave - requests in, READY/results/BUSY out
// Parameter LAT (1..4) is the issue-to-result latency of logic48_core; a
// results register adds the final edge, so a result issued at edge T is
// presented in the cycle after edge T+LAT. A tag shift register of depth LAT
// tracks valid/requester alongside the data so results leave in issue order.
// -----------------------------------------------------------------------------
module logic48_sched
    import logic48_pkg::*;
#(
    parameter int LAT = 2
) (
    input  logic              CLK,
    input  logic              RST,
    logic48_sched_if.slave    bus
);

    logic            w_gnt0;
    logic            w_gnt1;
    logic            w_issue;
    logic [OP_W-1:0] w_op;
    data_t           w_a;
    data_t           w_b;
    data_t           w_core_p;
    logic            w_any_tag;

    logic            r_ptr;
    tag_t            r_tag [LAT];
    logic            r_res_valid;
    logic            r_res_id;
    data_t           r_res_data;
    logic            r_busy;

    // Grant: a lone requester always wins; on contention the pointer decides.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (RST) begin
            w_gnt0 = 1'b0;
            w_gnt1 = 1'b0;
        end else if (bus.REQ0_VALID && bus.REQ1_VALID) begin
            w_gnt0 = ~r_ptr;
            w_gnt1 = r_ptr;
        end else begin
            w_gnt0 = bus.REQ0_VALID;
            w_gnt1 = bus.REQ1_VALID;
        end
    end

    assign w_issue        = w_gnt0 | w_gnt1;
    assign bus.REQ0_READY = w_gnt0;
    assign bus.REQ1_READY = w_gnt1;

    // Operand select for the granted requester (port 0 when idle; ignored then).
    always_comb begin
        w_op = bus.REQ0_OP;
        w_a  = bus.REQ0_A;
        w_b  = bus.REQ0_B;
        if (w_gnt1) begin
            w_op = bus.REQ1_OP;
            w_a  = bus.REQ1_A;
            w_b  = bus.REQ1_B;
        end else begin
            w_op = bus.REQ0_OP;
            w_a  = bus.REQ0_A;
            w_b  = bus.REQ0_B;
        end
    end

    logic48_core #(.LAT(LAT)) u_core (
        .CLK (CLK),
        .RST (RST),
        .OP  (w_op),
        .A   (w_a),
        .B   (w_b),
        .P   (w_core_p)
    );

    // Priority pointer: after a handshake the other port gets priority.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_ptr <= 1'b0;
        end else if (w_issue) begin
            r_ptr <= ~w_gnt1;
        end else begin
            r_ptr <= r_ptr;
        end
    end

    // Tag pipeline, aligned stage-for-stage with the core's data pipeline.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < LAT; i++) begin
                r_tag[i] <= '{valid: 1'b0, id: 1'b0};
            end
        end else begin
            r_tag[0] <= '{valid: w_issue, id: w_gnt1};
            for (int i = 1; i < LAT; i++) begin
                r_tag[i] <= r_tag[i-1];
            end
        end
    end

    // Any tag stage still carrying an operation.
    always_comb begin
        w_any_tag = 1'b0;
        for (int i = 0; i < LAT; i++) begin
            w_any_tag = w_any_tag | r_tag[i].valid;
        end
    end

    // Result register: loads only on a valid tag, so RES_DATA/RES_ID hold otherwise.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_res_valid <= 1'b0;
            r_res_id    <= 1'b0;
            r_res_data  <= {DATA_W{1'b0}};
            r_busy      <= 1'b0;
        end else begin
            r_res_valid <= r_tag[LAT-1].valid;
            if (r_tag[LAT-1].valid) begin
                r_res_id   <= r_tag[LAT-1].id;
                r_res_data <= w_core_p;
            end else begin
                r_res_id   <= r_res_id;
                r_res_data <= r_res_data;
            end
            // Next-cycle occupancy: a new issue, or any tag that will still be
            // in a stage or in the result register after this edge.
            r_busy <= w_issue | w_any_tag;
        end
    end

    assign bus.RES_VALID = r_res_valid;
    assign bus.RES_ID    = r_res_id;
    assign bus.RES_DATA  = r_res_data;
    assign bus.BUSY      = r_busy;

endmodule

// File: tb/tb_logic48_sched.sv
// -----------------------------------------------------------------------------
// tb_logic48_sched
// Self-checking bench for logic48_sched: directed sequences, an opcode table
// and randomized traffic, all checked against a scoreboard that predicts
// grants from the round-robin rule and results from issue time + LAT.
// -----------------------------------------------------------------------------
module tb_logic48_sched;
    import logic48_pkg::*;

    localparam int LAT = 2;

    logic CLK = 1'b0;
    logic RST;

    always #5 CLK = ~CLK;

    logic48_sched_if bus ();

    logic48_sched #(.LAT(LAT)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    typedef struct {
        int          id;
        logic [47:0] data;
        int          due;
    } exp_t;

    typedef struct {
        logic [2:0]  op;
        logic [47:0] a;
        logic [47:0] b;
        logic [47:0] exp;
    } vec_t;

    int          total = 0;
    int          bad   = 0;
    exp_t        q[$];
    logic [47:0] obs_q[$];
    int          cyc     = 0;
    int          ptr     = 0;
    logic [47:0] last    = 48'd0;
    int          obs_cnt = 0;
    int          obs_id0 = 0;

    function automatic logic [47:0] ref_op(input logic [2:0] op, input logic [47:0] a, input logic [47:0] b);
        case (op)
            3'd0:    return a & b;
            3'd1:    return a | b;
            3'd2:    return a ^ b;
            3'd3:    return ~(a & b);
            3'd4:    return ~(a | b);
            3'd5:    return ~(a ^ b);
            3'd6:    return a & ~b;
            default: return a;
        endcase
    endfunction

    task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic drive(input logic v0, input logic [2:0] op0, input logic [47:0] a0, input logic [47:0] b0,
                         input logic v1, input logic [2:0] op1, input logic [47:0] a1, input logic [47:0] b1);
        bus.REQ0_VALID = v0; bus.REQ0_OP = op0; bus.REQ0_A = a0; bus.REQ0_B = b0;
        bus.REQ1_VALID = v1; bus.REQ1_OP = op1; bus.REQ1_A = a1; bus.REQ1_B = b1;
    endtask

    // One clock: check READY against the rule, advance, check the result side.
    task automatic step();
        bit   g0, g1, rst_e, busy_e;
        exp_t e;
        #1;
        g0 = 1'b0; g1 = 1'b0;
        if (!RST) begin
            if (bus.REQ0_VALID && bus.REQ1_VALID) begin
                g0 = (ptr == 0); g1 = (ptr == 1);
            end else begin
                g0 = bus.REQ0_VALID; g1 = bus.REQ1_VALID;
            end
        end
        check("ready0", {47'd0, bus.REQ0_READY}, {47'd0, g0});
        check("ready1", {47'd0, bus.REQ1_READY}, {47'd0, g1});
        rst_e = RST;
        e.id = g1 ? 1 : 0;
        e.data = g1 ? ref_op(bus.REQ1_OP, bus.REQ1_A, bus.REQ1_B) : ref_op(bus.REQ0_OP, bus.REQ0_A, bus.REQ0_B);
        @(posedge CLK);
        cyc++;
        if (rst_e) begin
            q.delete(); last = 48'd0; ptr = 0;
        end else if (g0 || g1) begin
            e.due = cyc + LAT;
            q.push_back(e);
            ptr = g1 ? 0 : 1;
        end
        #1;
        if (bus.RES_VALID) begin
            obs_q.push_back(bus.RES_DATA);
            obs_cnt++;
            if (!bus.RES_ID) obs_id0++;
        end
        if (rst_e) begin
            check("rst_res_valid", {47'd0, bus.RES_VALID}, 48'd0);
            check("rst_res_id",    {47'd0, bus.RES_ID},    48'd0);
            check("rst_res_data",  bus.RES_DATA,           48'd0);
            check("rst_busy",      {47'd0, bus.BUSY},      48'd0);
        end else begin
            busy_e = (q.size() != 0);
            if (q.size() != 0 && q[0].due == cyc) begin
                e = q.pop_front();
                check("res_valid", {47'd0, bus.RES_VALID}, 48'd1);
                check("res_id",    {47'd0, bus.RES_ID},    48'(e.id));
                check("res_data",  bus.RES_DATA,           e.data);
                last = e.data;
            end else begin
                check("res_valid_idle", {47'd0, bus.RES_VALID}, 48'd0);
                check("res_data_hold",  bus.RES_DATA,           last);
            end
            check("busy", {47'd0, bus.BUSY}, {47'd0, busy_e});
        end
    endtask

    task automatic idle(input int n);
        drive(1'b0, 3'd0, 48'd0, 48'd0, 1'b0, 3'd0, 48'd0, 48'd0);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        RST = 1'b1;
        idle(2);
        RST = 1'b0;
    endtask

    vec_t tbl[8];
    int   c0, c1;
    logic [47:0] got;

    initial begin
        RST = 1'b1;
        drive(1'b0, 3'd0, 48'd0, 48'd0, 1'b0, 3'd0, 48'd0, 48'd0);
        idle(3);
        RST = 1'b0;
        idle(1);

        // Port 0 AND 3 & 514.
        obs_q.delete();
        drive(1'b1, 3'd0, 48'd3, 48'd514, 1'b0, 3'd0, 48'd0, 48'd0);
        step();
        idle(LAT);
        check("and_n", 48'(obs_q.size()), 48'd1);
        check("and_id", {47'd0, bus.RES_ID}, 48'd0);
        check("and_data", bus.RES_DATA, 48'd2);
        idle(2);

        // Contention every cycle: grants must alternate, starting at port 0.
        do_reset();
        obs_q.delete(); c0 = obs_cnt; c1 = obs_id0;
        drive(1'b1, 3'd2, 48'd2020, 48'd2000, 1'b1, 3'd1, 48'd10, 48'd14);
        for (int i = 0; i < 8; i++) step();
        idle(LAT + 1);
        check("alt_n", 48'(obs_cnt - c0), 48'd8);
        check("alt_id0", 48'(obs_id0 - c1), 48'd4);
        for (int i = 0; i < 8; i++) begin
            got = (i < obs_q.size()) ? obs_q[i] : 48'bx;
            check("alt_data", got, (i % 2 == 0) ? 48'd52 : 48'd14);
        end

        // Port 1 burst AND, ANDN, PASSA.
        obs_q.delete();
        drive(1'b0, 3'd0, 48'd0, 48'd0, 1'b1, 3'd0, 48'd1115, 48'd1111); step();
        drive(1'b0, 3'd0, 48'd0, 48'd0, 1'b1, 3'd6, 48'd1115, 48'd1111); step();
        drive(1'b0, 3'd0, 48'd0, 48'd0, 1'b1, 3'd7, 48'd1115, 48'd1111); step();
        idle(LAT + 1);
        check("burst_n", 48'(obs_q.size()), 48'd3);
        got = (obs_q.size() > 0) ? obs_q[0] : 48'bx; check("burst_and",  got, 48'd1107);
        got = (obs_q.size() > 1) ? obs_q[1] : 48'bx; check("burst_andn", got, 48'd8);
        got = (obs_q.size() > 2) ? obs_q[2] : 48'bx; check("burst_pass", got, 48'd1115);

        // Opcode table, issued back to back on port 0.
        tbl[0] = '{3'd0, 48'hFFFF0000FFFF, 48'h0F0F0F0F0F0F, 48'h0F0F00000F0F};
        tbl[1] = '{3'd1, 48'hFFFF0000FFFF, 48'h0F0F0F0F0F0F, 48'hFFFF0F0FFFFF};
        tbl[2] = '{3'd2, 48'hFFFF0000FFFF, 48'h0F0F0F0F0F0F, 48'hF0F00F0FF0F0};
        tbl[3] = '{3'd3, 48'hFFFF0000FFFF, 48'h0F0F0F0F0F0F, 48'hF0F0FFFFF0F0};
        tbl[4] = '{3'd4, 48'hFFFF0000FFFF, 48'h0F0F0F0F0F0F, 48'h0000F0F00000};
        tbl[5] = '{3'd5, 48'hFFFF0000FFFF, 48'h0F0F0F0F0F0F, 48'h0F0FF0F00F0F};
        tbl[6] = '{3'd6, 48'hFFFF0000FFFF, 48'h0F0F0F0F0F0F, 48'hF0F00000F0F0};
        tbl[7] = '{3'd7, 48'hFFFF0000FFFF, 48'h0F0F0F0F0F0F, 48'hFFFF0000FFFF};
        obs_q.delete();
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, tbl[i].op, tbl[i].a, tbl[i].b, 1'b0, 3'd0, 48'd0, 48'd0);
            step();
        end
        idle(LAT + 1);
        check("tbl_n", 48'(obs_q.size()), 48'd8);
        for (int i = 0; i < 8; i++) begin
            got = (i < obs_q.size()) ? obs_q[i] : 48'bx;
            check("tbl_data", got, tbl[i].exp);
        end

        // Reset with two operations in flight, then contention after release.
        do_reset();
        drive(1'b1, 3'd1, 48'd5, 48'd6, 1'b0, 3'd0, 48'd0, 48'd0); step();
        drive(1'b0, 3'd0, 48'd0, 48'd0, 1'b1, 3'd2, 48'd7, 48'd9); step();
        c0 = obs_cnt;
        RST = 1'b1;
        idle(2);
        RST = 1'b0;
        check("flush_n", 48'(obs_cnt - c0), 48'd0);
        c0 = obs_cnt; c1 = obs_id0;
        drive(1'b1, 3'd7, 48'd77, 48'd0, 1'b1, 3'd7, 48'd88, 48'd0);
        #1;
        check("post_rst_gnt0", {47'd0, bus.REQ0_READY}, 48'd1);
        check("post_rst_gnt1", {47'd0, bus.REQ1_READY}, 48'd0);
        step();
        idle(LAT + 2);
        check("post_rst_n", 48'(obs_cnt - c0), 48'd1);
        check("post_rst_id0", 48'(obs_id0 - c1), 48'd1);

        // Port 0 loses to port 1 and withdraws: no extra port-0 result.
        do_reset();
        c0 = obs_cnt; c1 = obs_id0;
        drive(1'b1, 3'd0, 48'd1, 48'd1, 1'b0, 3'd0, 48'd0, 48'd0); step();
        drive(1'b1, 3'd1, 48'd2, 48'd2, 1'b1, 3'd1, 48'd3, 48'd3); step();
        idle(LAT + 3);
        check("withdraw_n", 48'(obs_cnt - c0), 48'd2);
        check("withdraw_id0", 48'(obs_id0 - c1), 48'd1);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            drive(($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
                  {16'($urandom()), 32'($urandom())}, {16'($urandom()), 32'($urandom())},
                  ($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
                  {16'($urandom()), 32'($urandom())}, {16'($urandom()), 32'($urandom())});
            RST = ($urandom_range(0, 49) == 0);
            step();
        end
        RST = 1'b0;
        idle(LAT + 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
